fifo_word_packer: RTL
=====================

FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 8, width of one FIFO entry (byte lane).
REQ-002 SHALL have parameter PACK_RATIO, default 4, number of FIFO entries packed per output word; legal values are 2 to 16.
REQ-003 SHALL have parameter CNT_WIDTH, default $clog2(PACK_RATIO)+1, width of the lane counters.
REQ-004 CLK  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 Fifo_Empty  input  1  Empty flag of the upstream sync FIFO.
REQ-007 Fifo_Data  input  FIFO_WIDTH  upstream FIFO Data_out; valid the cycle after an accepted read.
REQ-008 Rd_Req  output  1  read request to the upstream FIFO.
REQ-009 Flush  input  1  level request to emit a partially filled word.
REQ-010 Out_Data  output  FIFO_WIDTH*PACK_RATIO  packed word; lane 0 (LSBs) holds the oldest entry.
REQ-011 Out_Keep  output  PACK_RATIO  per-lane valid mask for Out_Data.
REQ-012 Out_Valid  output  1  output word valid.
REQ-013 Out_Ready  input  1  downstream accepts the word.

Function
REQ-014 SHALL implement a two-state FSM: FILL (gathering lanes) and SEND (holding the word).
REQ-015 In FILL, Rd_Req SHALL be combinationally asserted iff !Fifo_Empty and issue_cnt < PACK_RATIO and Flush is not being honoured that cycle; in SEND, Rd_Req SHALL be 0.
REQ-016 Every cycle with Rd_Req=1 SHALL increment issue_cnt and set rd_pend=1 for the next cycle; otherwise rd_pend SHALL be 0.
REQ-017 When rd_pend=1, Fifo_Data SHALL be written into lane cap_cnt, the corresponding Out_Keep bit SHALL be set, and cap_cnt SHALL increment; the capture latency is exactly 1 cycle after Rd_Req.
REQ-018 When a capture makes cap_cnt equal PACK_RATIO, the FSM SHALL enter SEND on the same edge, and Out_Valid SHALL be 1 in the following cycle.
REQ-019 Flush SHALL be honoured in FILL only when cap_cnt > 0, rd_pend = 0, and issue_cnt equals cap_cnt; the FSM then enters SEND with the partial Out_Keep.
REQ-020 Flush with cap_cnt = 0 SHALL be ignored and SHALL produce no output word.
REQ-021 In SEND, Out_Valid SHALL be 1, and Out_Data/Out_Keep SHALL hold stable until Out_Valid && Out_Ready.
REQ-022 On handshake, the FSM SHALL return to FILL and clear issue_cnt, cap_cnt and Out_Keep on the same edge; Out_Data contents are don't-care once Out_Keep is cleared.
REQ-023 Unused lanes of a flushed word SHALL read 0.
REQ-024 Out_Ready while Out_Valid=0 SHALL have no effect.
REQ-025 Fifo_Empty rising mid-fill SHALL stall issuing without losing captured lanes; an already pending capture still completes.
REQ-026 Sustained throughput with Out_Ready held at 1 SHALL be one word per PACK_RATIO+2 cycles.

Reset
REQ-027 Asserting rst_n low SHALL asynchronously force FSM=FILL, issue_cnt=0, cap_cnt=0, rd_pend=0, Out_Data=0, Out_Keep=0, Out_Valid=0.
REQ-028 Rd_Req SHALL be 0 while rst_n is low.
REQ-029 A reset mid-fill or mid-send SHALL discard the partial word without emitting it.

Structure
REQ-030 The FSM state encoding (FILL=1'b0, SEND=1'b1) and the default FIFO_WIDTH/PACK_RATIO SHALL live in the shared package fifo_pkg.
REQ-031 The block SHALL be a single module with no sub-modules; it connects directly to SYNC_FIFO's Rd_Req/Data_out/Empty.

Verification
REQ-032 Stimulus: reset, then FIFO preloaded with 0x11,0x22,0x33,0x44 and Out_Ready=1 -> Rd_Req is asserted for 4 consecutive cycles, then Out_Data=0x44332211, Out_Keep=4'b1111, Out_Valid high for 1 cycle.
REQ-033 Stimulus: Out_Ready=0 for 5 cycles after a full word -> Out_Valid stays 1, Out_Data is stable, Rd_Req=0, and no further FIFO entries are consumed.
REQ-034 Stimulus: bytes 0xAA,0xBB, then the FIFO goes empty, then Flush is pulsed -> Out_Data=0x0000BBAA, Out_Keep=4'b0011.
REQ-035 Stimulus: Flush asserted with the FIFO empty and nothing captured -> no Out_Valid and no Rd_Req.
REQ-036 Stimulus: Fifo_Empty toggling every cycle while 8 bytes 0x01..0x08 are streamed -> words 0x04030201 then 0x08070605, with no loss or duplication.
REQ-037 Stimulus: rst_n pulled low after 2 captures -> all outputs return to 0 immediately; the next word is built from fresh data only.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO word packer: FSM encoding and default lane geometry.
package fifo_pkg;

    localparam int DEF_FIFO_WIDTH = 8;
    localparam int DEF_PACK_RATIO = 4;

    typedef enum logic {
        FILL = 1'b0,
        SEND = 1'b1
    } pack_state_t;

endpackage

// File: rtl/fifo_word_packer.sv
// Packs PACK_RATIO consecutive upstream FIFO entries into one wide word (lane 0 = oldest),
// with a flush path that emits a partially filled word when the source runs dry.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int PACK_RATIO = DEF_PACK_RATIO,
    parameter int CNT_WIDTH  = $clog2(PACK_RATIO) + 1
) (
    input  logic                             CLK,
    input  logic                             rst_n,
    input  logic                             Fifo_Empty,
    input  logic [FIFO_WIDTH-1:0]            Fifo_Data,
    output logic                             Rd_Req,
    input  logic                             Flush,
    output logic [FIFO_WIDTH*PACK_RATIO-1:0] Out_Data,
    output logic [PACK_RATIO-1:0]            Out_Keep,
    output logic                             Out_Valid,
    input  logic                             Out_Ready
);

    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(PACK_RATIO);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(PACK_RATIO - 1);

    pack_state_t                               state;
    logic        [CNT_WIDTH-1:0]               issue_cnt;
    logic        [CNT_WIDTH-1:0]               cap_cnt;
    logic                                      rd_pend;
    logic        [PACK_RATIO-1:0][FIFO_WIDTH-1:0] lanes;
    logic                                      flush_ok;

    // A flush is only taken once every issued read has landed, so no byte is in flight.
    assign flush_ok = (state == FILL) && Flush && (cap_cnt != '0) && !rd_pend
                      && (issue_cnt == cap_cnt);

    assign Rd_Req = rst_n && (state == FILL) && !Fifo_Empty && (issue_cnt < FULL_CNT)
                    && !flush_ok;

    assign Out_Data = lanes;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            rd_pend   <= 1'b0;
            lanes     <= '0;
            Out_Keep  <= '0;
            Out_Valid <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    rd_pend <= Rd_Req;
                    if (Rd_Req)
                        issue_cnt <= issue_cnt + 1'b1;
                    if (rd_pend) begin
                        for (int i = 0; i < PACK_RATIO; i++) begin
                            if (cap_cnt == CNT_WIDTH'(i)) begin
                                lanes[i]    <= Fifo_Data;
                                Out_Keep[i] <= 1'b1;
                            end
                        end
                        cap_cnt <= cap_cnt + 1'b1;
                        if (cap_cnt == LAST_CNT) begin
                            state     <= SEND;
                            Out_Valid <= 1'b1;
                        end
                    end else if (flush_ok) begin
                        state     <= SEND;
                        Out_Valid <= 1'b1;
                    end
                end
                SEND: begin
                    rd_pend <= 1'b0;
                    // Lanes are zeroed on handoff so a later partial word reads 0 in unused lanes.
                    if (Out_Ready) begin
                        state     <= FILL;
                        Out_Valid <= 1'b0;
                        issue_cnt <= '0;
                        cap_cnt   <= '0;
                        Out_Keep  <= '0;
                        lanes     <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
